// File: rtl/keypad_scan_driver.sv
// 4-column x 5-row matrix keypad scanner with frame-based debounce and a
// single-entry valid/ack event register that flags dropped presses.
`timescale 1ns/1ps
module keypad_scan_driver #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] col_drv,
    input  logic [4:0] row_in,
    output logic [4:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_down,
    output logic       overrun
);

    localparam logic [15:0] DWELL_LAST = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  DEB        = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONFIRM = 2'd1,
        HELD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    logic [4:0]  row_meta_q, row_sync_q;
    logic [15:0] dwell_q;
    logic [1:0]  col_q;
    logic [1:0]  acc_cnt_q;
    logic [4:0]  acc_code_q;
    state_t      state_q, state_d;
    logic [4:0]  cand_q, cand_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  key_code_q;
    logic        key_valid_q;
    logic        overrun_q;

    logic        tick;
    logic        frame_eval;
    logic [4:0]  row_low;
    logic [1:0]  row_cnt;
    logic [2:0]  row_idx;
    logic [2:0]  sum;
    logic [1:0]  frame_cnt;
    logic [4:0]  frame_code;
    logic        res_none, res_single;
    logic        press_evt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q <= '1;
            row_sync_q <= '1;
        end else begin
            row_meta_q <= row_in;
            row_sync_q <= row_meta_q;
        end
    end

    assign tick       = (dwell_q == DWELL_LAST);
    assign frame_eval = tick && (col_q == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_q <= '0;
            col_q   <= '0;
        end else if (tick) begin
            dwell_q <= '0;
            col_q   <= col_q + 2'd1;
        end else begin
            dwell_q <= dwell_q + 16'd1;
        end
    end

    assign col_drv = ~(4'b0001 << col_q);

    // Low-row count per frame saturates at 2: anything above one is MULTI.
    always_comb begin
        row_low = ~row_sync_q;
        row_cnt = 2'd0;
        row_idx = 3'd0;
        for (int r = 0; r < 5; r++) begin
            if (row_low[r]) begin
                if (row_cnt != 2'd2) row_cnt = row_cnt + 2'd1;
                row_idx = 3'(r);
            end
        end
        sum        = {1'b0, acc_cnt_q} + {1'b0, row_cnt};
        frame_cnt  = (sum > 3'd2) ? 2'd2 : sum[1:0];
        frame_code = (row_cnt == 2'd1) ? {row_idx, col_q} : acc_code_q;
        res_none   = (frame_cnt == 2'd0);
        res_single = (frame_cnt == 2'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt_q  <= '0;
            acc_code_q <= '0;
        end else if (frame_eval) begin
            acc_cnt_q  <= '0;
            acc_code_q <= '0;
        end else if (tick) begin
            acc_cnt_q  <= frame_cnt;
            acc_code_q <= frame_code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        press_evt = 1'b0;
        if (frame_eval) begin
            case (state_q)
                IDLE: begin
                    if (res_single) begin
                        cand_d = frame_code;
                        cnt_d  = 4'd1;
                        if (DEB == 4'd1) begin
                            state_d   = HELD;
                            press_evt = 1'b1;
                        end else begin
                            state_d = CONFIRM;
                        end
                    end
                end
                CONFIRM: begin
                    if (res_single && (frame_code == cand_q)) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q + 4'd1 == DEB) begin
                            state_d   = HELD;
                            press_evt = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                HELD: begin
                    if (res_none) begin
                        cnt_d   = 4'd1;
                        state_d = (DEB == 4'd1) ? IDLE : RELEASE;
                    end
                end
                RELEASE: begin
                    if (res_none) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q + 4'd1 == DEB) state_d = IDLE;
                    end else begin
                        state_d = HELD;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A new event may replace the pending one only when it is acked in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else if (press_evt) begin
            if (!key_valid_q || key_ack) begin
                key_code_q  <= cand_d;
                key_valid_q <= 1'b1;
            end else begin
                overrun_q <= 1'b1;
            end
        end else if (key_ack) begin
            key_valid_q <= 1'b0;
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    // The key stays down while its release is still being debounced.
    assign key_down  = (state_q == HELD) || (state_q == RELEASE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scan_driver.sv
// Keypad scanner bench: a matrix keypad model answers the column strobe and
// a scoreboard queue holds the press events expected from the scanner.
`timescale 1ns/1ps
module tb_keypad_scan_driver;

    localparam int SD = 4;
    localparam int DB = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  col_drv;
    logic [4:0]  row_in;
    logic [4:0]  key_code;
    logic        key_valid;
    logic        key_ack = 1'b0;
    logic        key_down;
    logic        overrun;
    logic [19:0] keys = '0;   // bit r*4+c = key at row r, column c pressed

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;

    typedef struct {
        logic [4:0] code;
        int         at;
    } evt_t;
    evt_t exp_q[$];

    logic vld_s = 1'b0;
    logic ack_s = 1'b0;

    keypad_scan_driver #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col_drv   (col_drv),
        .row_in    (row_in),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ack   (key_ack),
        .key_down  (key_down),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always_comb begin
        row_in = 5'h1f;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_drv[c]) row_in[r] = 1'b0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        vld_s <= key_valid;
        ack_s <= key_ack;
    end

    // An event load is visible as valid rising, or valid staying high across an ack.
    always @(negedge clk) begin
        if (rst_n && key_valid && (!vld_s || ack_s)) begin
            $display("event code=%b cyc=%0d", key_code, cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_event_cyc", 32'(cyc), 32'hffff_ffff);
            end else begin
                evt_t e;
                e = exp_q.pop_front();
                chk("event_code", 32'(key_code), 32'(e.code));
                chk("event_cycle", 32'(cyc), 32'(e.at));
            end
        end
    end

    task automatic goto(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        keys    = '0;
        key_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_col_drv", 32'(col_drv), 32'h0000_000e);
        chk("rst_key_valid", 32'(key_valid), 32'd0);
        chk("rst_key_code", 32'(key_code), 32'd0);
        chk("rst_key_down", 32'(key_down), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("pending_expected", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] e_col;

        // Idle scanning: column rotation and no events for 1000 cycles
        do_reset();
        for (int i = 0; i < 32; i++) begin
            goto(i);
            e_col = 4'b1111;
            e_col[(i / SD) % 4] = 1'b0;
            chk("scan_col_drv", 32'(col_drv), 32'(e_col));
        end
        goto(40);
        key_ack = 1'b1;
        goto(41);
        key_ack = 1'b0;
        chk("ack_while_idle_valid", 32'(key_valid), 32'd0);
        goto(1000);
        chk("idle_key_valid", 32'(key_valid), 32'd0);
        chk("idle_key_down", 32'(key_down), 32'd0);

        // Stable press row 2 / column 2 for 5 frames, then ack and release
        do_reset();
        keys[2*4+2] = 1'b1;
        exp_q.push_back('{code: 5'b01010, at: 48});
        goto(47);
        chk("press_valid_early", 32'(key_valid), 32'd0);
        goto(49);
        chk("press_valid", 32'(key_valid), 32'd1);
        chk("press_code", 32'(key_code), 32'b01010);
        chk("press_key_down", 32'(key_down), 32'd1);
        goto(50);
        key_ack = 1'b1;
        goto(51);
        key_ack = 1'b0;
        chk("ack_clears_valid", 32'(key_valid), 32'd0);
        goto(80);
        keys = '0;
        goto(130);
        chk("released_key_down", 32'(key_down), 32'd0);
        chk("released_valid", 32'(key_valid), 32'd0);

        // Short press (2 frames) gives nothing; a fresh press then confirms normally
        do_reset();
        keys[2*4+2] = 1'b1;
        goto(32);
        keys = '0;
        goto(60);
        chk("short_valid", 32'(key_valid), 32'd0);
        chk("short_key_down", 32'(key_down), 32'd0);
        goto(64);
        keys[1*4+0] = 1'b1;
        exp_q.push_back('{code: 5'b00100, at: 112});
        goto(120);
        chk("after_short_valid", 32'(key_valid), 32'd1);
        chk("after_short_code", 32'(key_code), 32'b00100);

        // Two rows in one column (MULTI), then a NONE/SINGLE bounce
        do_reset();
        keys[0*4+1] = 1'b1;
        keys[1*4+1] = 1'b1;
        goto(80);
        keys = '0;
        for (int f = 0; f < 6; f++) begin
            goto(80 + 16 * f);
            keys[3*4+3] = (f % 2 == 0);
        end
        goto(176);
        keys = '0;
        goto(200);
        chk("multi_bounce_valid", 32'(key_valid), 32'd0);
        chk("multi_bounce_key_down", 32'(key_down), 32'd0);

        // Second press without ack is dropped and sets overrun
        do_reset();
        keys[0] = 1'b1;
        exp_q.push_back('{code: 5'b00000, at: 48});
        goto(64);
        keys = '0;
        goto(112);
        keys[4*4+3] = 1'b1;
        goto(150);
        chk("overrun_before_drop", 32'(overrun), 32'd0);
        goto(170);
        chk("drop_code_kept", 32'(key_code), 32'b00000);
        chk("drop_valid", 32'(key_valid), 32'd1);
        chk("drop_overrun", 32'(overrun), 32'd1);
        goto(176);
        keys = '0;

        // Ack in the same cycle as the second confirm loads the new code
        do_reset();
        keys[0] = 1'b1;
        exp_q.push_back('{code: 5'b00000, at: 48});
        goto(64);
        keys = '0;
        goto(112);
        keys[4*4+3] = 1'b1;
        exp_q.push_back('{code: 5'b10011, at: 160});
        goto(159);
        key_ack = 1'b1;
        goto(160);
        key_ack = 1'b0;
        goto(170);
        chk("ack_confirm_code", 32'(key_code), 32'b10011);
        chk("ack_confirm_valid", 32'(key_valid), 32'd1);
        chk("ack_confirm_overrun", 32'(overrun), 32'd0);

        // Asynchronous reset pulse while an event is pending
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_col_drv", 32'(col_drv), 32'h0000_000e);
        chk("async_rst_valid", 32'(key_valid), 32'd0);
        chk("async_rst_code", 32'(key_code), 32'd0);
        chk("async_rst_key_down", 32'(key_down), 32'd0);
        @(negedge clk);
        @(negedge clk);
        keys  = '0;
        rst_n = 1'b1;
        goto(4);
        chk("restart_col_drv", 32'(col_drv), 32'h0000_000d);
        goto(40);
        chk("end_pending_expected", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scan_driver.md
KEYPAD_SCAN_DRIVER -- requirements
Module: keypad_scan_driver

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 1000: clk cycles each column is driven (dwell); legal range 4..65535.
REQ-002 The block SHALL have parameter DEBOUNCE_SCANS, default 4: identical consecutive frame results needed to confirm a press or release; legal range 1..15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state is clocked on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port col_drv, output, 4 bits: column strobe, active-low one-hot.
REQ-006 The block SHALL have port row_in, input, 5 bits: row sense lines, active-low, asynchronous to clk.
REQ-007 The block SHALL have port key_code, output, 5 bits: [1:0] = column index 0..3, [4:2] = row index 0..4.
REQ-008 The block SHALL have port key_valid, output, 1 bit: a confirmed press event is pending.
REQ-009 The block SHALL have port key_ack, input, 1 bit: the consumer accepts the pending event.
REQ-010 The block SHALL have port key_down, output, 1 bit: a confirmed key is currently held.
REQ-011 The block SHALL have port overrun, output, 1 bit: sticky flag, a confirmed press was dropped.

Function
REQ-012 row_in SHALL pass through a 2-flop synchronizer before any use.
REQ-013 A dwell counter SHALL count 0..SCAN_DIV-1; on terminal count col_drv SHALL rotate 1110 -> 1101 -> 1011 -> 0111 -> 1110.
REQ-014 The synchronized rows SHALL be sampled only on the terminal-count cycle of each dwell, for the column currently driven.
REQ-015 A frame is 4 dwells (4*SCAN_DIV cycles); a frame result is NONE (no low row in any column), SINGLE(code) (exactly one low row in exactly one column) or MULTI (anything else).
REQ-016 The frame result SHALL be evaluated once per frame, at the end of the column-3 dwell.
REQ-017 The FSM SHALL have states IDLE, CONFIRM, HELD and RELEASE.
REQ-018 IDLE: on SINGLE(c), latch c as the candidate, set the count to 1 and go to CONFIRM; otherwise stay.
REQ-019 CONFIRM: on SINGLE with the same candidate, increment the count; any other result returns to IDLE.
REQ-020 CONFIRM: when the count reaches DEBOUNCE_SCANS, go to HELD and issue the event; with DEBOUNCE_SCANS=1, IDLE SHALL go directly to HELD.
REQ-021 HELD: key_down = 1; on NONE, set the count to 1 and go to RELEASE; SINGLE(same) or MULTI stays in HELD.
REQ-022 RELEASE: NONE increments the count and reaching DEBOUNCE_SCANS goes to IDLE; anything else returns to HELD.
REQ-023 Press latency from a stable single key SHALL be DEBOUNCE_SCANS frame evaluations, with the first evaluation counting as 1.
REQ-024 Handshake: an event SHALL load key_code and set key_valid when key_valid=0, or when key_valid=1 and key_ack=1 in the same cycle.
REQ-025 key_valid SHALL clear the cycle after key_ack=1 unless a new event loads in that cycle.
REQ-026 key_code SHALL stay stable while key_valid=1.
REQ-027 key_ack while key_valid=0 SHALL be ignored.
REQ-028 An event arriving while key_valid=1 without key_ack SHALL be dropped and SHALL set overrun; the pending key_code is unchanged.
REQ-029 Release SHALL generate no event.

Reset
REQ-030 While rst_n=0 (asynchronous assert): col_drv=1110, key_code=0, key_valid=0, key_down=0, overrun=0, FSM=IDLE, all counters and synchronizer flops = 0/inactive (synchronizer flops = 1).
REQ-031 Reset asserted mid-scan or mid-event SHALL discard the candidate and any pending event.
REQ-032 After rst_n deassertion, scanning SHALL start at column 0 with the dwell count 0.
REQ-033 overrun SHALL be cleared only by reset.

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=3; frame = 16 cycles)
REQ-034 Reset, no keys -> col_drv cycles 1110/1101/1011/0111, 4 cycles each; key_valid stays 0 for 1000 cycles.
REQ-035 Row 2 held low only while col_drv=1011, for 5 frames -> key_valid rises after the 3rd frame evaluation with key_code=5'b01010 and key_down=1; ack -> key_valid=0 the next cycle.
REQ-036 Press lasting 2 frames, then released -> no event, FSM back in IDLE.
REQ-037 Rows 0 and 1 both low in column 1 -> MULTI, no event; a bounce pattern alternating NONE/SINGLE each frame -> no event.
REQ-038 Two distinct presses each held 4 frames, no ack -> first key_code retained, overrun=1; ack on the same cycle as the second confirm -> second code loaded and overrun=0.
REQ-039 rst_n pulsed low for 1 cycle while key_valid=1 -> key_valid=0 and col_drv=1110 immediately, without waiting for clk.
